// File: rtl/proc_arb_pkg.sv
// Shared types and constants for the processing-datapath arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package proc_arb_pkg;

  // Arbiter control states: granting, waiting for in-flight words, parked.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int ERR_CNT_W = 16;

  // Edges from the transfer edge to the response register update:
  // dp_data_in register, datapath input register, DP_LAT result stages,
  // ERR_LAG flag stages.
  function automatic int rsp_latency(input int dp_lat, input int err_lag);
    return 2 + dp_lat + err_lag;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after the priority pointer.
// Latency: combinational.
// Backpressure: no grant while enable is low.
// Ports: valid (per-requester request), enable, ptr (priority start),
//        grant (one-hot), grant_idx (encoded), grant_vld (any grant).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] idx;

  // Scan NUM_REQ positions starting at ptr, wrapping; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (enable && !grant_vld && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_arbiter.sv
// Shares the add-constant datapath among NUM_REQ requesters, tags each word with its ID.
// Latency: transfer edge k -> rsp_valid after edge k+2+DP_LAT+ERR_LAG; 1 word/cycle.
// Backpressure: req_ready one-hot grant (none during flush/drain/hold); responses never stall.
// Ports: clk/reset; req_valid/req_data/req_ready requester side; dp_data_in,
//        dp_processed_data, dp_error_flag datapath side; rsp_* result strobe;
//        flush/flush_done drain handshake; busy; err_count saturating error count.
module proc_arbiter
  import proc_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int DP_LAT  = 2,
  parameter  int ERR_LAG = 1,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         dp_data_in,
  input  logic [DATA_W-1:0]         dp_processed_data,
  input  logic                      dp_error_flag,
  output logic                      rsp_valid,
  output logic [IDX_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy,
  output logic [ERR_CNT_W-1:0]      err_count
);

  // One tag slot per register between the transfer edge and the response register.
  localparam int TAG_D = rsp_latency(DP_LAT, ERR_LAG) - 0;

  arb_state_t           state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic                 arb_en;
  logic [DATA_W-1:0]    grant_dat;
  logic [TAG_D-1:0]     tag_vld_q;
  logic [IDX_W-1:0]     tag_id_q [TAG_D];
  logic [DATA_W-1:0]    align_q  [ERR_LAG];
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Flush gates grants combinationally so the cycle it is first seen grants nothing.
  assign arb_en = !reset && (state_q == RUN) && !flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid     (req_valid),
    .enable    (arb_en),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;
  assign ptr_nxt   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_dat = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Idle cycles feed zeros so the datapath never sees a stale word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      dp_data_in <= '0;
    end else begin
      dp_data_in <= grant_vld ? grant_dat : '0;
      if (grant_vld) ptr_q <= ptr_nxt;
    end
  end

  // Tag pipeline: slot 0 is the newest word, slot TAG_D-1 lines up with the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int i = 0; i < TAG_D; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[TAG_D-2:0], grant_vld};
      tag_id_q[0] <= grant_idx;
      for (int i = 1; i < TAG_D; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // Result is held back ERR_LAG cycles to meet its late error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ERR_LAG; i++) align_q[i] <= '0;
    end else begin
      align_q[0] <= dp_processed_data;
      for (int i = 1; i < ERR_LAG; i++) align_q[i] <= align_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= tag_vld_q[TAG_D-1];
      if (tag_vld_q[TAG_D-1]) begin
        rsp_id    <= tag_id_q[TAG_D-1];
        rsp_data  <= align_q[ERR_LAG-1];
        rsp_error <= dp_error_flag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_error && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
  assign busy      = |tag_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) state_q <= DRAIN;
        end
        DRAIN: begin
          // Wait for the last response strobe to leave as well.
          if (!busy && !rsp_valid) begin
            state_q    <= HOLD;
            flush_done <= 1'b1;
          end
        end
        HOLD: begin
          if (!flush) begin
            state_q    <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_arbiter.sv
// Directed bench for proc_arbiter with a stand-in add-constant datapath.
// Latency: n/a.
// Backpressure: n/a.
module tb_proc_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam logic [31:0] ADD_C = 32'hA5A5A5A5;
  localparam logic [31:0] THR   = 32'hFFFFFF00;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         dp_data_in;
  logic [DATA_W-1:0]         dp_processed_data;
  logic                      dp_error_flag;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_error;
  logic                      flush;
  logic                      flush_done;
  logic                      busy;
  logic [15:0]               err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .DP_LAT  (2),
    .ERR_LAG (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .dp_data_in        (dp_data_in),
    .dp_processed_data (dp_processed_data),
    .dp_error_flag     (dp_error_flag),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
    .rsp_error         (rsp_error),
    .flush             (flush),
    .flush_done        (flush_done),
    .busy              (busy),
    .err_count         (err_count)
  );

  // Datapath stand-in: input register, then two result stages; flag one cycle later.
  logic [31:0] m_in_q, m_sum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_q            <= '0;
      m_sum_q           <= '0;
      dp_processed_data <= '0;
      dp_error_flag     <= 1'b0;
    end else begin
      m_in_q            <= dp_data_in;
      m_sum_q           <= m_in_q + ADD_C;
      dp_processed_data <= m_sum_q;
      dp_error_flag     <= (dp_processed_data > THR);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    flush     = 1'b0;
    #3;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (dp_data_in !== 32'h0) begin errors++; $display("FAIL reset_dp_data_in got=%h exp=0", dp_data_in); end
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_error} !== 36'h0) begin errors++; $display("FAIL reset_rsp got=%b/%h/%h/%b exp=0", rsp_valid, rsp_id, rsp_data, rsp_error); end
    checks++; if ({flush_done, busy, err_count} !== 18'h0) begin errors++; $display("FAIL reset_status got=%b/%b/%h exp=0", flush_done, busy, err_count); end
    req_valid = 4'b0000;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_id[$];
    logic [31:0] exp_dat[$];
    logic [3:0]  exp_rdy;
    logic [31:0] w;
    int got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 8) begin
        for (int i = 0; i < NUM_REQ; i++) req_data[i*32 +: 32] = 32'h1000_0000 + 32'(cyc*16 + i);
        req_valid = 4'b1111;
        #1;
        exp_rdy = 4'b0001 << (cyc % 4);
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
        w = 32'h1000_0000 + 32'(cyc*16 + (cyc % 4));
        exp_id.push_back(2'(cyc % 4));
        exp_dat.push_back(w + ADD_C);
      end else begin
        req_valid = 4'b0000;
      end
      step();
      if (rsp_valid) begin
        got++;
        if (exp_id.size() == 0) begin
          checks++; errors++; $display("FAIL rr_extra_rsp id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          checks++;
          if (rsp_id !== exp_id[0] || rsp_data !== exp_dat[0] || rsp_error !== 1'b0) begin
            errors++; $display("FAIL rr_rsp got=%0d/%h/%b exp=%0d/%h/0", rsp_id, rsp_data, rsp_error, exp_id[0], exp_dat[0]);
          end
          void'(exp_id.pop_front());
          void'(exp_dat.pop_front());
        end
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL rr_rsp_count got=%0d exp=8", got); end
  endtask

  task automatic test_single();
    req_data            = '0;
    req_data[64 +: 32]  = 32'h0000_0001;
    req_valid           = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (dp_data_in !== 32'h1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue got=%h/%b exp=00000001/1", dp_data_in, busy); end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c < 5) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp edge=k+%0d got=%b exp=0", c, rsp_valid); end
      end else begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hA5A5A5A6 || rsp_error !== 1'b0) begin
          errors++; $display("FAIL single_rsp got=%b/%0d/%h/%b exp=1/2/a5a5a5a6/0", rsp_valid, rsp_id, rsp_data, rsp_error);
        end
      end
    end
    step();
    checks++; if (rsp_valid !== 1'b0 || dp_data_in !== 32'h0) begin errors++; $display("FAIL single_after got=%b/%h exp=0/0", rsp_valid, dp_data_in); end
  endtask

  task automatic test_error_path();
    logic [31:0] words [3];
    logic [31:0] exp_res [3];
    logic        exp_err [3];
    int got = 0;
    words[0] = 32'h5A5A5B5A; exp_res[0] = 32'h0000_00FF; exp_err[0] = 1'b0;
    words[1] = 32'h5A5A5A5B; exp_res[1] = 32'h0000_0000; exp_err[1] = 1'b0;
    words[2] = 32'h5A5A5A5A; exp_res[2] = 32'hFFFF_FFFF; exp_err[2] = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 3) begin
        req_data  = '0;
        req_data[32 +: 32] = words[cyc];
        req_valid = 4'b0010;
      end else begin
        req_valid = 4'b0000;
      end
      step();
      if (rsp_valid) begin
        checks++;
        if (got > 2) begin
          errors++; $display("FAIL err_extra_rsp data=%h", rsp_data);
        end else if (rsp_id !== 2'd1 || rsp_data !== exp_res[got] || rsp_error !== exp_err[got]) begin
          errors++; $display("FAIL err_rsp n=%0d got=%0d/%h/%b exp=1/%h/%b", got, rsp_id, rsp_data, rsp_error, exp_res[got], exp_err[got]);
        end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL err_rsp_count got=%0d exp=3", got); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_count got=%h exp=0001", err_count); end
  endtask

  task automatic test_flush();
    int got = 0;
    int grants_seen = 0;
    logic [31:0] exp_d;
    for (int n = 0; n < 3; n++) begin
      req_data  = '0;
      req_data[0 +: 32] = 32'h10 + 32'(n);
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_load_grant n=%0d got=%b exp=0001", n, req_ready); end
      step();
    end
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_first_cycle_grant got=%b exp=0000", req_ready); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (req_ready !== 4'b0000) grants_seen++;
      if (rsp_valid) begin
        exp_d = 32'h10 + 32'(got) + ADD_C;
        checks++; if (rsp_data !== exp_d || rsp_id !== 2'd0) begin errors++; $display("FAIL flush_rsp n=%0d got=%0d/%h exp=0/%h", got, rsp_id, rsp_data, exp_d); end
        got++;
      end
      if (flush_done) break;
    end
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_done_timeout got=%b exp=1", flush_done); end
    checks++; if (got != 3) begin errors++; $display("FAIL flush_rsp_count got=%0d exp=3", got); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (grants_seen != 0) begin errors++; $display("FAIL flush_grants got=%0d exp=0", grants_seen); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_grant got=%b exp=0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0010 || flush_done !== 1'b0) begin errors++; $display("FAIL resume got=%b/%b exp=0010/0", req_ready, flush_done); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL idle_flush_k got=%b exp=0", flush_done); end
    step();
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL idle_flush_k1 got=%b exp=1", flush_done); end
    flush = 1'b0;
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL idle_flush_release got=%b exp=0", flush_done); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    req_data = '0;
    req_data[32 +: 32] = 32'h0000_0111;
    req_data[64 +: 32] = 32'h0000_0222;
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant0 got=%b exp=0010", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant1 got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (dp_data_in !== 32'h222 || busy !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%h/%b exp=00000222/1", dp_data_in, busy); end
    reset = 1'b1;
    #1;
    checks++; if (dp_data_in !== 32'h0 || busy !== 1'b0 || err_count !== 16'h0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got=%h/%b/%h/%b exp=0/0/0/0", dp_data_in, busy, err_count, rsp_valid);
    end
    step();
    step();
    reset = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (rsp_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale_rsp got=%0d exp=0", stale); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_restart got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_saturation();
    int err_rsp = 0;
    force dut.err_cnt_q = 16'hFFFE;
    step();
    release dut.err_cnt_q;
    step();
    checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", err_count); end
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 3) begin
        req_data  = '0;
        req_data[0 +: 32] = 32'h5A5A5A5A;
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      step();
      if (rsp_valid && rsp_error) err_rsp++;
    end
    checks++; if (err_rsp != 3) begin errors++; $display("FAIL sat_err_rsp got=%0d exp=3", err_rsp); end
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got=%h exp=ffff", err_count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_error_path();
    test_flush();
    test_flush_idle();
    test_reset_midflight();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
